qtree_nat_serializer: RTL and testbench

QTREE_NAT_SERIALIZER -- requirements
Module: qtree_nat_serializer

---
 rtl/qtree_nat_serializer.sv | 136 +++++++++++++
 tb/tb_qtree_nat_serializer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_nat_serializer.sv
// Postorder serializer for a heap-resident quad tree (QTree Nat).
// The tree is walked with an explicit stack of {kind, ptr} entries, and one token is emitted per node.
module qtree_nat_serializer #(
  parameter  int PTR_W       = 16,
  parameter  int VAL_W       = 32,
  parameter  int STACK_DEPTH = 64,
  localparam int NODE_W      = 2 + ((VAL_W > 4*PTR_W) ? VAL_W : 4*PTR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              root_valid,
  output logic              root_ready,
  input  logic [PTR_W-1:0]  root_ptr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [PTR_W-1:0]  mem_req_addr,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [NODE_W-1:0] mem_rsp_data,
  output logic [NODE_W-1:0] o_QTree_Nat_tdata,
  output logic              o_QTree_Nat_tvalid,
  input  logic              o_QTree_Nat_tready,
  output logic              o_QTree_Nat_tlast,
  output logic              busy,
  output logic              err_overflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int SW = AW + 1;

  localparam logic [1:0] TAG_NODE = 2'd2;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, ERR} state_t;

  typedef struct packed {
    logic             kind;  // 0: fetch ptr, 1: emit QNode marker
    logic [PTR_W-1:0] ptr;
  } entry_t;

  state_t            state;
  logic [SW-1:0]     sp;
  logic [NODE_W-1:0] token;
  entry_t            stack [STACK_DEPTH];

  entry_t            top;
  logic [AW-1:0]     top_idx;
  logic [1:0]        rsp_tag;
  logic              room;
  logic              push_root;
  logic              expand;

  assign top_idx   = AW'(sp - SW'(1));
  assign top       = stack[top_idx];
  assign rsp_tag   = mem_rsp_data[1:0];
  // An expansion keeps the parent (as a marker) and adds four children.
  assign room      = (int'(sp) + 4) <= STACK_DEPTH;
  assign push_root = (state == IDLE) && root_valid;
  assign expand    = (state == WAIT) && mem_rsp_valid && (rsp_tag == TAG_NODE) && room;

  // NOTE: the stack RAM has no reset; sp alone defines which entries are live,
  // so stale contents are never observed and the array can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push_root) begin
      stack[0] <= '{kind: 1'b0, ptr: root_ptr};
    end else if (expand) begin
      stack[top_idx] <= '{kind: 1'b1, ptr: top.ptr};
      // Child c3 goes deepest and c0 ends on top, so c0 is emitted first.
      for (int k = 0; k < 4; k++) begin
        stack[AW'(sp + SW'(3 - k))] <= '{kind: 1'b0, ptr: mem_rsp_data[2 + PTR_W*k +: PTR_W]};
      end
    end
  end

  // NOTE: every register in this block is updated with non-blocking assignments.
  // The case arms therefore read the pre-edge sp and state, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sp           <= '0;
      token        <= '0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (root_valid) begin
            sp    <= SW'(1);
            state <= FETCH;
          end
        end
        FETCH: begin
          if (top.kind) begin
            token <= NODE_W'(TAG_NODE);
            state <= EMIT;
          end else if (top.ptr == '0) begin
            token <= '0;
            state <= EMIT;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (rsp_tag != TAG_NODE) begin
              token <= mem_rsp_data;
              state <= EMIT;
            end else if (room) begin
              sp    <= sp + SW'(4);
              state <= FETCH;
            end else begin
              err_overflow <= 1'b1;
              state        <= ERR;
            end
          end
        end
        EMIT: begin
          if (o_QTree_Nat_tready) begin
            sp    <= sp - SW'(1);
            state <= (sp == SW'(1)) ? IDLE : FETCH;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign root_ready         = (state == IDLE);
  assign busy               = (state != IDLE);
  assign mem_req_valid      = (state == FETCH) && !top.kind && (top.ptr != '0);
  assign mem_req_addr       = mem_req_valid ? top.ptr : '0;
  assign mem_rsp_ready      = (state == WAIT);
  assign o_QTree_Nat_tvalid = (state == EMIT);
  assign o_QTree_Nat_tdata  = token;
  assign o_QTree_Nat_tlast  = (state == EMIT) && (sp == SW'(1));

endmodule

// File: tb/tb_qtree_nat_serializer.sv
// Directed bench for qtree_nat_serializer with a behavioural heap and a token sink.
// It covers leaf, null and small-tree roots, random stalls, stack overflow and reset during a read.
module tb_qtree_nat_serializer;

  localparam int PTR_W  = 16;
  localparam int VAL_W  = 32;
  localparam int DEPTH  = 64;
  localparam int NODE_W = 66;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              root_valid = 1'b0;
  logic              root_ready;
  logic [PTR_W-1:0]  root_ptr = '0;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PTR_W-1:0]  mem_req_addr;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [NODE_W-1:0] mem_rsp_data;
  logic [NODE_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              busy;
  logic              err_overflow;

  always #5 clk = ~clk;

  qtree_nat_serializer #(.PTR_W(PTR_W), .VAL_W(VAL_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .root_valid(root_valid), .root_ready(root_ready), .root_ptr(root_ptr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .o_QTree_Nat_tdata(tdata), .o_QTree_Nat_tvalid(tvalid), .o_QTree_Nat_tready(tready),
    .o_QTree_Nat_tlast(tlast), .busy(busy), .err_overflow(err_overflow)
  );

  logic [NODE_W-1:0] heap [256];
  int vectors = 0;
  int miscompares = 0;

  bit model_en = 1'b1;
  bit stall = 1'b0;
  bit pend = 1'b0;
  int pend_delay = 0;
  logic [PTR_W-1:0] pend_addr = '0;
  bit prev_req_stall = 1'b0;
  logic [PTR_W-1:0] prev_addr = '0;
  bit prev_tok_stall = 1'b0;
  logic [NODE_W-1:0] prev_tdata = '0;
  logic prev_tlast = 1'b0;

  int req_log[$];
  logic [NODE_W-1:0] tok_log[$];
  bit last_log[$];
  int overlap_viol = 0;
  int req_stab_viol = 0;
  int tok_stab_viol = 0;
  int tvalid_seen = 0;

  localparam logic [NODE_W-1:0] TOK_NONE = 66'h0;
  localparam logic [NODE_W-1:0] TOK_MARK = 66'h2;
  localparam logic [NODE_W-1:0] TOK_ERR  = {32'h0, 32'hC0FFEE00, 2'b11};
  logic [NODE_W-1:0] exp_tree [5];
  int exp_req [4] = '{32'h20, 32'h30, 32'h40, 32'h50};

  function automatic logic [NODE_W-1:0] qval(input int v);
    return {32'h0, 32'(v), 2'b01};
  endfunction

  function automatic logic [NODE_W-1:0] qnode(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0), 2'b10};
  endfunction

  // Heap model: at most one read in flight, optional random ready stalls and response delay.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        prev_req_stall = 1'b0;
        continue;
      end
      if (reset) begin
        pend = 1'b0; prev_req_stall = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        continue;
      end
      mem_req_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      mem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_delay > 0) pend_delay--;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = heap[pend_addr[7:0]];
        end
      end
      #1;
      if (prev_req_stall && (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr)) req_stab_viol++;
      if (mem_rsp_valid && mem_rsp_ready) pend = 1'b0;
      if (mem_req_valid === 1'b1 && mem_req_ready) begin
        req_log.push_back(int'(mem_req_addr));
        if (pend) overlap_viol++;
        pend = 1'b1;
        pend_addr = mem_req_addr;
        pend_delay = stall ? $urandom_range(0, 3) : 0;
      end
      prev_req_stall = (mem_req_valid === 1'b1) && !mem_req_ready;
      prev_addr = mem_req_addr;
    end
  end

  // Token sink with optional random backpressure; also watches for tdata changes during a stall.
  initial begin
    tready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tok_stall = 1'b0;
        tready = 1'b0;
        continue;
      end
      tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_tok_stall && (tvalid !== 1'b1 || tdata !== prev_tdata || tlast !== prev_tlast)) tok_stab_viol++;
      if (tvalid === 1'b1) tvalid_seen++;
      if (tvalid === 1'b1 && tready) begin
        tok_log.push_back(tdata);
        last_log.push_back(tlast);
      end
      prev_tok_stall = (tvalid === 1'b1) && !tready;
      prev_tdata = tdata;
      prev_tlast = tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    req_log.delete(); tok_log.delete(); last_log.delete();
    overlap_viol = 0; req_stab_viol = 0; tok_stab_viol = 0; tvalid_seen = 0;
  endtask

  task automatic start_root(input logic [PTR_W-1:0] p);
    @(negedge clk);
    root_valid = 1'b1;
    root_ptr   = p;
    @(negedge clk);
    root_valid = 1'b0;
    root_ptr   = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (root_ready === 1'b1 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (root_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_root_ready: got %b want 1", root_ready);
    end
    vectors++;
    if ({mem_req_valid, mem_rsp_ready, tvalid, tlast, busy, err_overflow} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000",
               {mem_req_valid, mem_rsp_ready, tvalid, tlast, busy, err_overflow});
    end
    vectors++;
    if (mem_req_addr !== '0 || tdata !== '0) begin
      miscompares++; $display("FAIL reset_data: addr %h tdata %h want 0", mem_req_addr, tdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_leaf();
    bit ok;
    clear_logs();
    start_root(16'h0010);
    #1;
    vectors++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0010) begin
      miscompares++; $display("FAIL leaf_req_latency: valid %b addr %h want 1 0010", mem_req_valid, mem_req_addr);
    end
    wait_idle(100, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++; $display("FAIL leaf_timeout: got %b want 1", ok);
    end
    vectors++;
    if (req_log.size() != 1 || (req_log.size() == 1 && req_log[0] != 32'h10)) begin
      miscompares++; $display("FAIL leaf_requests: count %0d want 1 at 0x10", req_log.size());
    end
    vectors++;
    if (tok_log.size() != 1 || tok_log[0] !== qval(7) || last_log[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL leaf_token: count %0d first %h last %b want 1 %h 1",
               tok_log.size(), (tok_log.size() > 0) ? tok_log[0] : '0,
               (last_log.size() > 0) ? last_log[0] : 1'b0, qval(7));
    end
  endtask

  task automatic test_null();
    bit ok;
    clear_logs();
    start_root(16'h0000);
    wait_idle(100, ok);
    vectors++;
    if (ok !== 1'b1 || req_log.size() != 0) begin
      miscompares++; $display("FAIL null_requests: idle %b requests %0d want 1 0", ok, req_log.size());
    end
    vectors++;
    if (tok_log.size() != 1 || tok_log[0] !== TOK_NONE || last_log[0] !== 1'b1) begin
      miscompares++; $display("FAIL null_token: count %0d want one QNone with tlast", tok_log.size());
    end
  endtask

  task automatic test_tree();
    bit ok;
    clear_logs();
    start_root(16'h0020);
    wait_idle(200, ok);
    vectors++;
    if (ok !== 1'b1 || req_log.size() != 4 || tok_log.size() != 5) begin
      miscompares++;
      $display("FAIL tree_counts: idle %b requests %0d tokens %0d want 1 4 5", ok, req_log.size(), tok_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (req_log[i] != exp_req[i]) begin
          miscompares++; $display("FAIL tree_req[%0d]: got %h want %h", i, req_log[i], exp_req[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (tok_log[i] !== exp_tree[i] || last_log[i] !== (i == 4)) begin
          miscompares++;
          $display("FAIL tree_tok[%0d]: got %h last %b want %h last %b", i, tok_log[i], last_log[i], exp_tree[i], i == 4);
        end
      end
    end
  endtask

  task automatic test_stalls();
    bit ok;
    stall = 1'b1;
    for (int run = 0; run < 4; run++) begin
      clear_logs();
      start_root(16'h0020);
      wait_idle(1000, ok);
      vectors++;
      if (ok !== 1'b1 || tok_log.size() != 5) begin
        miscompares++; $display("FAIL stall_run%0d_count: idle %b tokens %0d want 1 5", run, ok, tok_log.size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          vectors++;
          if (tok_log[i] !== exp_tree[i] || last_log[i] !== (i == 4)) begin
            miscompares++; $display("FAIL stall_run%0d_tok[%0d]: got %h want %h", run, i, tok_log[i], exp_tree[i]);
          end
        end
      end
      vectors++;
      if (overlap_viol != 0 || req_stab_viol != 0 || tok_stab_viol != 0) begin
        miscompares++;
        $display("FAIL stall_run%0d_protocol: overlap %0d req_unstable %0d tok_unstable %0d want 0 0 0",
                 run, overlap_viol, req_stab_viol, tok_stab_viol);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_overflow();
    bit hit = 1'b0;
    bit ok;
    for (int i = 0; i < 30; i++)
      heap[8'h80 + i] = (i < 29) ? qnode(32'h81 + i, 0, 0, 0) : qval(9);
    clear_logs();
    start_root(16'h0080);
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (err_overflow === 1'b1) hit = 1'b1;
    end
    vectors++;
    if (hit !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flag: got %b want 1", err_overflow);
    end
    // Sixteen levels fit in 64 entries; the sixteenth expansion overflows.
    vectors++;
    if (req_log.size() != 16) begin
      miscompares++; $display("FAIL ovf_requests: got %0d want 16", req_log.size());
    end
    @(negedge clk);
    root_valid = 1'b1;
    root_ptr   = 16'h0010;
    repeat (40) @(negedge clk);
    root_valid = 1'b0;
    #2;
    vectors++;
    if (tvalid_seen != 0 || tok_log.size() != 0 || req_log.size() != 16) begin
      miscompares++;
      $display("FAIL ovf_silent: tvalid cycles %0d tokens %0d requests %0d want 0 0 16",
               tvalid_seen, tok_log.size(), req_log.size());
    end
    vectors++;
    if (busy !== 1'b1 || root_ready !== 1'b0 || err_overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_hold: busy %b ready %b err %b want 1 0 1", busy, root_ready, err_overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_idle(5, ok);
    vectors++;
    if (ok !== 1'b1 || err_overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_reset: idle %b err %b want 1 0", ok, err_overflow);
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen = 1'b0;
    bit bad = 1'b0;
    bit ok;
    model_en = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    start_root(16'h0020);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mem_rsp_ready === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++; $display("FAIL rst_wait_reached: got %b want 1", seen);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (root_ready !== 1'b1 || {mem_req_valid, mem_rsp_ready, tvalid, tlast, busy, err_overflow} !== 6'b0) begin
      miscompares++; $display("FAIL rst_mid_outputs: ready %b flags %b want 1 000000", root_ready,
                              {mem_req_valid, mem_rsp_ready, tvalid, tlast, busy, err_overflow});
    end
    @(negedge clk);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = heap[8'h20];
    repeat (3) begin
      @(negedge clk);
      #1;
      if (mem_rsp_ready !== 1'b0 || busy !== 1'b0 || tvalid !== 1'b0 || mem_req_valid !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("FAIL rst_late_rsp: got reaction %b want 0", bad);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    model_en = 1'b1;
    @(negedge clk);
    clear_logs();
    start_root(16'h0010);
    wait_idle(100, ok);
    vectors++;
    if (ok !== 1'b1 || req_log.size() != 1 || tok_log.size() != 1 ||
        (tok_log.size() == 1 && (tok_log[0] !== qval(7) || last_log[0] !== 1'b1))) begin
      miscompares++;
      $display("FAIL rst_recover: idle %b requests %0d tokens %0d want 1 1 1", ok, req_log.size(), tok_log.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) heap[i] = '0;
    heap[8'h10] = qval(7);
    heap[8'h20] = qnode(32'h30, 0, 32'h40, 32'h50);
    heap[8'h30] = qval(1);
    heap[8'h40] = qval(2);
    heap[8'h50] = TOK_ERR;
    exp_tree[0] = qval(1);
    exp_tree[1] = TOK_NONE;
    exp_tree[2] = qval(2);
    exp_tree[3] = TOK_ERR;
    exp_tree[4] = TOK_MARK;

    test_reset();
    test_leaf();
    test_null();
    test_tree();
    test_stalls();
    test_overflow();
    test_reset_in_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
